io_port_bank: RTL

Parametrised multi-channel successor to the single-register I/O block. It sits on the CPU's shared tri-state data bus and gives software NUM_CH independent I/O channels. Each channel has a DEPTH-entry receive FIFO, filled from an external valid/ready source, and a DEPTH-entry transmit FIFO, drained to an external valid/ready sink. The bus selects one channel per access, and sticky overflow/underflow flags record dropped or empty accesses.

---
 rtl/io_port_bank.sv | 125 ++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// Multi-channel I/O port bank on a shared tri-state CPU bus.
// Each channel has an RX FIFO fed externally and read by the bus, and a TX FIFO written by the bus and drained externally.
module io_port_bank #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     program_mode,
    inout  wire  [DATA_W-1:0]        data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_en,
    input  logic                     out_en,
    input  logic [NUM_CH*DATA_W-1:0] ext_rx_data,
    input  logic [NUM_CH-1:0]        ext_rx_valid,
    output logic [NUM_CH-1:0]        ext_rx_ready,
    output logic [NUM_CH*DATA_W-1:0] ext_tx_data,
    output logic [NUM_CH-1:0]        ext_tx_valid,
    input  logic [NUM_CH-1:0]        ext_tx_ready,
    output logic [NUM_CH-1:0]        rx_empty,
    output logic [NUM_CH-1:0]        tx_full,
    output logic [NUM_CH-1:0]        tx_ovf,
    output logic [NUM_CH-1:0]        rx_unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                     rd_req;
    logic                     wr_req;
    logic [NUM_CH-1:0]        hit;
    logic [NUM_CH*DATA_W-1:0] rx_head;
    logic [DATA_W-1:0]        rd_val;

    // A read takes priority over a simultaneous write.
    assign rd_req = out_en & ~program_mode;
    assign wr_req = in_en & ~out_en & ~program_mode;

    // An out-of-range select hits no channel, so it reads 0 and touches nothing.
    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            hit[k] = (sel == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] rx_mem [DEPTH];
        logic [DATA_W-1:0] tx_mem [DEPTH];
        logic [PTR_W-1:0]  rx_rd, rx_wr, tx_rd, tx_wr;
        logic [CNT_W-1:0]  rx_cnt, tx_cnt;
        logic              rx_full, tx_empty;
        logic              rx_push, rx_pop, tx_push, tx_pop;
        logic              ovf_q, unf_q;

        assign rx_full  = (rx_cnt == CNT_W'(DEPTH));
        assign tx_empty = (tx_cnt == '0);

        assign rx_empty[k]     = (rx_cnt == '0);
        assign tx_full[k]      = (tx_cnt == CNT_W'(DEPTH));
        assign ext_rx_ready[k] = ~rx_full & ~rst & ~clr;
        assign ext_tx_valid[k] = ~tx_empty;
        assign tx_ovf[k]       = ovf_q;
        assign rx_unf[k]       = unf_q;

        assign rx_push = ext_rx_valid[k] & ~rx_full;
        assign rx_pop  = rd_req & hit[k] & ~rx_empty[k];
        assign tx_push = wr_req & hit[k] & ~tx_full[k];
        assign tx_pop  = ~tx_empty & ext_tx_ready[k];

        assign rx_head[k*DATA_W +: DATA_W]     = rx_empty[k] ? '0 : rx_mem[rx_rd];
        assign ext_tx_data[k*DATA_W +: DATA_W] = tx_empty ? '0 : tx_mem[tx_rd];

        always_ff @(posedge clk) begin
            if (rx_push) rx_mem[rx_wr] <= ext_rx_data[k*DATA_W +: DATA_W];
            if (tx_push) tx_mem[tx_wr] <= data;
        end

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                rx_rd  <= '0;
                rx_wr  <= '0;
                rx_cnt <= '0;
                tx_rd  <= '0;
                tx_wr  <= '0;
                tx_cnt <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                if (rx_push) rx_wr <= rx_wr + PTR_W'(1);
                if (rx_pop)  rx_rd <= rx_rd + PTR_W'(1);
                if (tx_push) tx_wr <= tx_wr + PTR_W'(1);
                if (tx_pop)  tx_rd <= tx_rd + PTR_W'(1);

                case ({rx_push, rx_pop})
                    2'b10:   rx_cnt <= rx_cnt + CNT_W'(1);
                    2'b01:   rx_cnt <= rx_cnt - CNT_W'(1);
                    default: rx_cnt <= rx_cnt;
                endcase

                case ({tx_push, tx_pop})
                    2'b10:   tx_cnt <= tx_cnt + CNT_W'(1);
                    2'b01:   tx_cnt <= tx_cnt - CNT_W'(1);
                    default: tx_cnt <= tx_cnt;
                endcase

                if (wr_req && hit[k] && tx_full[k])  ovf_q <= 1'b1;
                if (rd_req && hit[k] && rx_empty[k]) unf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (hit[k]) rd_val = rx_head[k*DATA_W +: DATA_W];
        end
    end

    assign data = rd_req ? rd_val : 'z;

endmodule
